// File: rtl/button_pulse_bank.sv
`default_nettype none
// ============================================================================
//  Module   : button_pulse_bank
//  Purpose  : N-channel push-button front end. Each channel has a 2-FF
//             synchroniser, a counter debounce, a one-shot press pulse and
//             optional auto-repeat while held.
//             Parameter ranges: DEBOUNCE_CYC >= 1, REPEAT_DELAY >= 2,
//             REPEAT_PERIOD >= 2.
//  Revision : 1.0  initial release
// ============================================================================
module button_pulse_bank #(
    parameter int           N             = 4,
    parameter int           DEBOUNCE_CYC  = 20000,
    parameter int           REPEAT_DELAY  = 50000000,
    parameter int           REPEAT_PERIOD = 10000000,
    parameter logic [N-1:0] REPEAT_MASK   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_in,
    input  logic         en,
    output logic [N-1:0] pulse,
    output logic [N-1:0] level,
    output logic [N-1:0] repeating
);

    // Out-of-range settings are clamped; a period below 2 would merge repeat pulses.
    localparam int c_DEB    = (DEBOUNCE_CYC  < 1) ? 1 : DEBOUNCE_CYC;
    localparam int c_DELAY  = (REPEAT_DELAY  < 2) ? 2 : REPEAT_DELAY;
    localparam int c_PERIOD = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
    localparam int c_HMAX   = (c_DELAY > c_PERIOD) ? c_DELAY : c_PERIOD;
    localparam int c_DW     = (c_DEB > 1) ? $clog2(c_DEB) : 1;
    localparam int c_HW     = $clog2(c_HMAX + 1);

    localparam logic [c_DW-1:0] c_DCNT_LAST   = c_DW'(c_DEB - 1);
    localparam logic [c_HW-1:0] c_DELAY_LAST  = c_HW'(c_DELAY - 1);
    localparam logic [c_HW-1:0] c_PERIOD_LAST = c_HW'(c_PERIOD - 1);
    localparam logic [c_HW-1:0] c_HCNT_SAT    = '1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HELD   = 2'd1;
    localparam logic [1:0] S_REPEAT = 2'd2;

    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic            r_level;
        logic [c_DW-1:0] r_dcnt;
        logic            w_settle;
        logic            w_rise;
        logic            w_fall;
        logic [1:0]      r_state;
        logic [1:0]      w_state_nxt;
        logic [c_HW-1:0] r_hcnt;
        logic [c_HW-1:0] w_hcnt_nxt;
        logic            w_press_evt;
        logic            w_repeat_evt;
        logic            r_pulse;
        logic            w_pulse_nxt;

        assign w_settle = (r_sync2[i] != r_level) && (r_dcnt == c_DCNT_LAST);
        assign w_rise   = w_settle &&  r_sync2[i];
        assign w_fall   = w_settle && !r_sync2[i];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_level <= 1'b0;
                r_dcnt  <= '0;
            end else if (r_sync2[i] == r_level) begin
                r_dcnt  <= '0;
            end else if (w_settle) begin
                r_level <= r_sync2[i];
                r_dcnt  <= '0;
            end else begin
                r_dcnt  <= r_dcnt + 1'b1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= S_IDLE;
                r_hcnt  <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_hcnt  <= w_hcnt_nxt;
                r_pulse <= w_pulse_nxt;
            end
        end

        // Hold counter starts at 0 on the press, so the first repeat lands
        // exactly REPEAT_DELAY edges after the press pulse.
        always_comb begin
            w_state_nxt  = r_state;
            w_hcnt_nxt   = r_hcnt;
            w_press_evt  = 1'b0;
            w_repeat_evt = 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        w_press_evt = 1'b1;
                        w_state_nxt = S_HELD;
                        w_hcnt_nxt  = '0;
                    end
                end
                S_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = S_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (REPEAT_MASK[i] && (r_hcnt == c_DELAY_LAST)) begin
                        w_repeat_evt = 1'b1;
                        w_state_nxt  = S_REPEAT;
                        w_hcnt_nxt   = '0;
                    end else if (r_hcnt != c_HCNT_SAT) begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                S_REPEAT: begin
                    if (w_fall) begin
                        w_state_nxt = S_IDLE;
                        w_hcnt_nxt  = '0;
                    end else if (r_hcnt == c_PERIOD_LAST) begin
                        w_repeat_evt = 1'b1;
                        w_hcnt_nxt   = '0;
                    end else begin
                        w_hcnt_nxt = r_hcnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end

        always_comb begin
            w_pulse_nxt = en && (w_press_evt || w_repeat_evt);
        end

        assign pulse[i]     = r_pulse;
        assign level[i]     = r_level;
        assign repeating[i] = (r_state == S_REPEAT);
    end

endmodule
`default_nettype wire
